// File: rtl/bus_interconnect.sv
// bus_interconnect: CPU-to-peripheral interconnect.
//   Decodes the CPU address into one of N_DEV slots and routes the read/write strobes to that
//   slot. It registers the ready pulse and read data back to the CPU. A slave that stays silent
//   is timed out. The first bus error is logged: unmapped address, timeout, or read and write
//   high together.
// Ports:
//   clk, reset            clock (rising edge), synchronous active-low reset
//   read, write, address  CPU request, held until ready; data_out is the CPU write data
//   data_in, ready        registered read data and one-cycle response pulse to the CPU
//   dev_read, dev_write   per-slot strobes, active only while waiting on the selected slot
//   dev_addr, wdata       offset within the selected slot, write data to all slots
//   dev_ready, dev_rdata  per-slot response pulse and read data (slot i at [i*DW+:DW])
//   err, err_code, err_addr, err_clr   sticky first-error log and its clear
//   busy                  high whenever a transaction is in flight
module bus_interconnect #(
    parameter int unsigned           AW       = 8,
    parameter int unsigned           DW       = 8,
    parameter int unsigned           N_DEV    = 4,
    parameter logic [N_DEV*AW-1:0]   BASE     = {8'h80, 8'h00, 8'hfe, 8'hff},
    parameter logic [N_DEV*AW-1:0]   MASK     = {8'h80, 8'h80, 8'hff, 8'hff},
    parameter int unsigned           TIMEOUT  = 16,
    parameter logic [DW-1:0]         ERR_DATA = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                read,
    input  logic                write,
    input  logic [AW-1:0]       address,
    input  logic [DW-1:0]       data_out,
    output logic [DW-1:0]       data_in,
    output logic                ready,
    output logic [N_DEV-1:0]    dev_read,
    output logic [N_DEV-1:0]    dev_write,
    output logic [AW-1:0]       dev_addr,
    output logic [DW-1:0]       wdata,
    input  logic [N_DEV-1:0]    dev_ready,
    input  logic [N_DEV*DW-1:0] dev_rdata,
    output logic                err,
    output logic [1:0]          err_code,
    output logic [AW-1:0]       err_addr,
    input  logic                err_clr,
    output logic                busy
);

    localparam int unsigned SW = (N_DEV > 1) ? $clog2(N_DEV) : 1;
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e          state_q;
    logic [SW-1:0]   sel_q;
    logic [AW-1:0]   addr_q;
    logic [CW-1:0]   cnt_q;

    logic            hit;
    logic [SW-1:0]   hit_idx;
    logic [AW-1:0]   sel_mask;
    logic [DW-1:0]   sel_rdata;
    logic            sel_ready;
    logic            timed_out;
    logic            err_set;
    logic [1:0]      err_set_code;
    logic [AW-1:0]   err_set_addr;

    // Descending scan so the lowest matching slot is the one left in hit_idx.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = N_DEV - 1; i >= 0; i--) begin
            if ((address & MASK[i*AW +: AW]) == BASE[i*AW +: AW]) begin
                hit     = 1'b1;
                hit_idx = SW'(i);
            end
        end
    end

    always_comb begin
        sel_mask  = '0;
        sel_rdata = '0;
        sel_ready = 1'b0;
        dev_read  = '0;
        dev_write = '0;
        for (int i = 0; i < N_DEV; i++) begin
            if (sel_q == SW'(i)) begin
                sel_mask     = MASK[i*AW +: AW];
                sel_rdata    = dev_rdata[i*DW +: DW];
                sel_ready    = dev_ready[i];
                dev_read[i]  = (state_q == StWait) && read;
                dev_write[i] = (state_q == StWait) && write;
            end
        end
    end

    assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    // Error detected at this edge; logged only if nothing is logged yet and no clear is pending.
    always_comb begin
        err_set      = 1'b0;
        err_set_code = 2'b00;
        err_set_addr = address;
        unique case (state_q)
            StIdle: begin
                if (read && write) begin
                    err_set      = 1'b1;
                    err_set_code = 2'b11;
                end else if ((read ^ write) && !hit) begin
                    err_set      = 1'b1;
                    err_set_code = 2'b01;
                end
            end
            StWait: begin
                if (!sel_ready && (read || write) && timed_out) begin
                    err_set      = 1'b1;
                    err_set_code = 2'b10;
                    err_set_addr = addr_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            sel_q    <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
            ready    <= 1'b0;
            data_in  <= '0;
            err      <= 1'b0;
            err_code <= 2'b00;
            err_addr <= '0;
        end else begin
            ready <= 1'b0;

            if (err_clr) begin
                err      <= 1'b0;
                err_code <= 2'b00;
                err_addr <= '0;
            end else if (err_set && !err) begin
                err      <= 1'b1;
                err_code <= err_set_code;
                err_addr <= err_set_addr;
            end

            unique case (state_q)
                StIdle: begin
                    if (read && write) begin
                        state_q <= StDone;
                        ready   <= 1'b1;
                        data_in <= ERR_DATA;
                    end else if (read ^ write) begin
                        addr_q <= address;
                        if (hit) begin
                            sel_q   <= hit_idx;
                            cnt_q   <= '0;
                            state_q <= StWait;
                        end else begin
                            state_q <= StDone;
                            ready   <= 1'b1;
                            data_in <= ERR_DATA;
                        end
                    end
                end
                StWait: begin
                    if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    if (sel_ready) begin
                        state_q <= StDone;
                        ready   <= 1'b1;
                        if (read) begin
                            data_in <= sel_rdata;
                        end
                    end else if (!read && !write) begin
                        state_q <= StIdle;
                    end else if (timed_out) begin
                        state_q <= StDone;
                        ready   <= 1'b1;
                        data_in <= ERR_DATA;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign dev_addr = addr_q & ~sel_mask;
    assign wdata    = data_out;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_bus_interconnect.sv
module tb_bus_interconnect;

    localparam int TO = 16;

    // Default decode map, slot order 0..3.
    localparam logic [7:0] BS  [4] = '{8'hff, 8'hfe, 8'h00, 8'h80};
    localparam logic [7:0] MSK [4] = '{8'hff, 8'hff, 8'h80, 8'h80};

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [7:0]  address = '0;
    logic [7:0]  data_out = '0;
    logic        err_clr = 1'b0;
    logic [3:0]  dev_ready = '0;
    logic [31:0] dev_rdata = '0;

    logic [7:0]  data_in;
    logic        ready;
    logic [3:0]  dev_read;
    logic [3:0]  dev_write;
    logic [7:0]  dev_addr;
    logic [7:0]  wdata;
    logic        err;
    logic [1:0]  err_code;
    logic [7:0]  err_addr;
    logic        busy;

    // Second instance: two slots at 0x00 and 0x80 only, short timeout.
    logic [1:0]  d2_dev_ready = '0;
    logic [15:0] d2_dev_rdata = '0;
    logic [7:0]  d2_data_in;
    logic        d2_ready;
    logic [1:0]  d2_dev_read;
    logic [1:0]  d2_dev_write;
    logic [7:0]  d2_dev_addr;
    logic [7:0]  d2_wdata;
    logic        d2_err;
    logic [1:0]  d2_err_code;
    logic [7:0]  d2_err_addr;
    logic        d2_busy;

    always #5 clk = ~clk;

    bus_interconnect #(.TIMEOUT(TO)) u_dut (
        .clk(clk), .reset(reset), .read(read), .write(write), .address(address),
        .data_out(data_out), .data_in(data_in), .ready(ready), .dev_read(dev_read),
        .dev_write(dev_write), .dev_addr(dev_addr), .wdata(wdata), .dev_ready(dev_ready),
        .dev_rdata(dev_rdata), .err(err), .err_code(err_code), .err_addr(err_addr),
        .err_clr(err_clr), .busy(busy)
    );

    bus_interconnect #(
        .N_DEV(2), .BASE(16'h8000), .MASK(16'hffff), .TIMEOUT(4)
    ) u_dut2 (
        .clk(clk), .reset(reset), .read(read), .write(write), .address(address),
        .data_out(data_out), .data_in(d2_data_in), .ready(d2_ready), .dev_read(d2_dev_read),
        .dev_write(d2_dev_write), .dev_addr(d2_dev_addr), .wdata(d2_wdata),
        .dev_ready(d2_dev_ready), .dev_rdata(d2_dev_rdata), .err(d2_err),
        .err_code(d2_err_code), .err_addr(d2_err_addr), .err_clr(err_clr), .busy(d2_busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: CPU-visible data register and error log.
    logic [7:0] dm = '0;
    logic       em = 1'b0;
    logic [1:0] cm = '0;
    logic [7:0] am = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int decode(input logic [7:0] a);
        for (int i = 0; i < 4; i++) begin
            if ((a & MSK[i]) == BS[i]) return i;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One CPU transaction; lat = cycle at which the selected slot pulses dev_ready (0/large = never).
    task automatic do_txn(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                          input int lat, input logic [7:0] rdat, input bit clr);
        int         slot;
        bit         is_err;
        logic [1:0] code;
        int         r;
        logic [3:0] stb;
        slot   = decode(a);
        is_err = 1'b0;
        code   = 2'b00;
        if (rd && wr) begin
            is_err = 1'b1; code = 2'b11; r = 1;
        end else if (slot < 0) begin
            is_err = 1'b1; code = 2'b01; r = 1;
        end else if (lat >= 1 && lat <= TO) begin
            r = lat + 1;
        end else begin
            is_err = 1'b1; code = 2'b10; r = TO + 1;
        end
        if (clr) begin
            em = 1'b0; cm = 2'b00; am = '0;
        end else if (is_err && !em) begin
            em = 1'b1; cm = code; am = a;
        end
        if (is_err) dm = 8'h00;
        else if (rd) dm = rdat;

        read = rd; write = wr; address = a; data_out = wd; err_clr = clr;
        for (int c = 1; c <= 40; c++) begin
            step();
            dev_ready = 4'($urandom());
            dev_rdata = $urandom();
            if (slot >= 0) begin
                dev_ready[slot] = (c == lat);
                dev_rdata[slot*8 +: 8] = rdat;
            end
            stb = (c < r && !is_err && slot >= 0) ? 4'(1 << slot) : 4'b0000;
            if (c < r && code == 2'b10) stb = 4'(1 << slot);
            check("dev_read", dev_read, rd ? stb : 4'b0000);
            check("dev_write", dev_write, wr ? stb : 4'b0000);
            check("ready", ready, c == r);
            check("busy", busy, 1'b1);
            if (c == 1 && slot >= 0 && !(rd && wr)) begin
                check("dev_addr", dev_addr, a & ~MSK[slot]);
                check("wdata", wdata, wd);
            end
            if (c == r) begin
                check("data_in", data_in, dm);
                check("err", err, em);
                check("err_code", err_code, cm);
                check("err_addr", err_addr, am);
                break;
            end
            if (c == 40) check("ready_timeout", 1'b0, 1'b1);
        end
        read = 1'b0; write = 1'b0; err_clr = 1'b0; dev_ready = '0;
        step();
        check("idle_ready", ready, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("data_hold", data_in, dm);
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        em = 1'b0; cm = 2'b00; am = '0;
        check("clr_err", err, 1'b0);
        check("clr_code", err_code, 2'b00);
        check("clr_addr", err_addr, 8'h00);
    endtask

    initial begin
        // Reset values.
        reset = 1'b0;
        step();
        step();
        check("rst_ready", ready, 1'b0);
        check("rst_data", data_in, 8'h00);
        check("rst_err", err, 1'b0);
        check("rst_code", err_code, 2'b00);
        check("rst_addr", err_addr, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_strobe", {dev_read, dev_write}, 8'h00);
        reset = 1'b1;
        step();

        // Directed transactions.
        do_txn(1, 0, 8'h05, 8'h00, 1, 8'h3c, 0);
        do_txn(0, 1, 8'h90, 8'ha5, 3, 8'h00, 0);
        do_txn(1, 0, 8'hff, 8'h00, 99, 8'h11, 0);
        clear_err();
        do_txn(1, 1, 8'h10, 8'h00, 1, 8'h00, 0);
        do_txn(1, 1, 8'h20, 8'h00, 1, 8'h00, 0);
        do_txn(1, 0, 8'hfe, 8'h00, TO, 8'h77, 0);
        do_txn(1, 0, 8'h7f, 8'h00, TO + 1, 8'h44, 0);
        clear_err();
        do_txn(1, 1, 8'h30, 8'h00, 1, 8'h00, 1);
        do_txn(0, 1, 8'hc3, 8'h5a, 2, 8'h00, 1);

        // CPU abort while waiting.
        read = 1'b1; address = 8'h05;
        step();
        check("abort_strobe", dev_read, 4'b0100);
        step();
        read = 1'b0;
        step();
        check("abort_busy", busy, 1'b0);
        check("abort_ready", ready, 1'b0);
        check("abort_err", err, em);
        step();
        check("abort_ready2", ready, 1'b0);

        // Reset during WAIT.
        read = 1'b1; address = 8'h05;
        step();
        step();
        reset = 1'b0;
        step();
        check("midrst_busy", busy, 1'b0);
        check("midrst_ready", ready, 1'b0);
        check("midrst_strobe", dev_read, 4'b0000);
        reset = 1'b1; read = 1'b0;
        dm = '0; em = 1'b0; cm = 2'b00; am = '0;
        step();
        check("midrst_ready2", ready, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 150; n++) begin
            bit rd;
            bit wr;
            int kind;
            kind = int'($urandom_range(0, 7));
            rd = (kind == 0) || (kind >= 4);
            wr = (kind <= 3);
            do_txn(rd, wr, 8'($urandom()), 8'($urandom()), int'($urandom_range(1, 20)),
                   8'($urandom()), ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 7) == 0) clear_err();
        end

        // Sparse two-slot map: unmapped and short timeout.
        reset = 1'b0;
        step();
        reset = 1'b1;
        read = 1'b1; address = 8'h85;
        step();
        check("d2_unmapped_ready", d2_ready, 1'b1);
        check("d2_unmapped_code", d2_err_code, 2'b01);
        check("d2_unmapped_addr", d2_err_addr, 8'h85);
        check("d2_unmapped_strobe", d2_dev_read, 2'b00);
        read = 1'b0; err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("d2_clr_err", d2_err, 1'b0);
        check("d2_clr_code", d2_err_code, 2'b00);
        read = 1'b1; address = 8'h80;
        for (int c = 1; c <= 5; c++) begin
            step();
            if (c == 1) begin
                check("d2_strobe", d2_dev_read, 2'b10);
                check("d2_dev_addr", d2_dev_addr, 8'h00);
            end
            check("d2_to_ready", d2_ready, c == 5);
        end
        check("d2_to_code", d2_err_code, 2'b10);
        check("d2_to_addr", d2_err_addr, 8'h80);
        check("d2_to_data", d2_data_in, 8'h00);
        read = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
